// File: rtl/dmem_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dmem_write_buffer
// Brief    : Posted-store FIFO between the memory-stage bus and the L1 D-cache
//            port; loads bypass it unless they hit a queued word.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dmem_action_cyc,
    input  logic                     dmem_action_stb,
    input  logic                     dmem_write,
    input  logic [1:0]               dmem_byte_enable,
    input  logic [15:0]              dmem_address,
    input  logic [15:0]              dmem_wdata,
    output logic                     dmem_resp,
    output logic [15:0]              dmem_data_out,
    output logic                     cache_cyc,
    output logic                     cache_stb,
    output logic                     cache_we,
    output logic [1:0]               cache_sel,
    output logic [15:0]              cache_adr,
    output logic [15:0]              cache_wdata,
    input  logic                     cache_ack,
    input  logic [15:0]              cache_rdata,
    output logic                     buf_empty,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]    c_FULL  = (c_PTR_W + 1)'(DEPTH);

    localparam logic [1:0] c_R_IDLE  = 2'd0;
    localparam logic [1:0] c_R_LOAD  = 2'd1;
    localparam logic [1:0] c_R_RESP  = 2'd2;

    localparam logic [1:0] c_P_IDLE  = 2'd0;
    localparam logic [1:0] c_P_DRAIN = 2'd1;
    localparam logic [1:0] c_P_LOAD  = 2'd2;

    logic [1:0]          r_req_state;
    logic [1:0]          r_port_state;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;
    logic [14:0]         r_fifo_adr  [DEPTH];
    logic [15:0]         r_fifo_data [DEPTH];
    logic [1:0]          r_fifo_mask [DEPTH];
    logic                r_drain_all;
    logic                r_load_flushed;
    logic [15:0]         r_load_adr;
    logic [1:0]          r_load_sel;
    logic [15:0]         r_data_out;

    logic                w_req_valid;
    logic                w_store_acc;
    logic                w_load_req;
    logic                w_load_issue;
    logic                w_pop;
    logic [DEPTH-1:0]    w_hit_vec;
    logic                w_hit;

    assign w_req_valid = dmem_action_cyc & dmem_action_stb;
    assign w_store_acc = (r_req_state == c_R_IDLE) && w_req_valid && dmem_write && (r_count != c_FULL);
    assign w_load_req  = (r_req_state == c_R_IDLE) && w_req_valid && !dmem_write;
    assign w_pop       = (r_port_state == c_P_DRAIN) && cache_ack;

    // An entry is live when its distance from the head is below the count,
    // so the head still being drained takes part in the hit check.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [c_PTR_W-1:0] w_off;
            assign w_off         = c_PTR_W'(gi) - r_rd_ptr;
            assign w_hit_vec[gi] = ({1'b0, w_off} < r_count) &&
                                   (r_fifo_adr[gi] == dmem_address[15:1]);
        end
    endgenerate

    assign w_hit        = |w_hit_vec;
    assign w_load_issue = w_load_req && (r_port_state == c_P_IDLE) && !w_hit &&
                          (!r_drain_all || (r_count == '0));

    always_ff @(posedge clk) begin
        if (w_store_acc) begin
            r_fifo_adr[r_wr_ptr]  <= dmem_address[15:1];
            r_fifo_data[r_wr_ptr] <= dmem_wdata;
            r_fifo_mask[r_wr_ptr] <= dmem_byte_enable;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_store_acc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_state    <= c_R_IDLE;
            r_drain_all    <= 1'b0;
            r_load_flushed <= 1'b0;
            r_data_out     <= '0;
        end else begin
            case (r_req_state)
                c_R_IDLE: begin
                    if (w_store_acc) begin
                        r_req_state <= c_R_RESP;
                    end else if (w_load_issue) begin
                        r_req_state    <= c_R_LOAD;
                        r_load_flushed <= 1'b0;
                        r_drain_all    <= 1'b0;
                    end else if (w_load_req && w_hit) begin
                        r_drain_all <= 1'b1;
                    end else if (!w_req_valid) begin
                        r_drain_all <= 1'b0;
                    end
                end
                c_R_LOAD: begin
                    // A flushed load still finishes on the cache side; its data is dropped.
                    if (cache_ack) begin
                        if (r_load_flushed || !dmem_action_cyc) begin
                            r_req_state <= c_R_IDLE;
                        end else begin
                            r_data_out  <= cache_rdata;
                            r_req_state <= c_R_RESP;
                        end
                    end else if (!dmem_action_cyc) begin
                        r_load_flushed <= 1'b1;
                    end
                end
                c_R_RESP: r_req_state <= c_R_IDLE;
                default:  r_req_state <= c_R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_port_state <= c_P_IDLE;
            r_load_adr   <= '0;
            r_load_sel   <= '0;
        end else begin
            case (r_port_state)
                c_P_IDLE: begin
                    if (w_load_issue) begin
                        r_port_state <= c_P_LOAD;
                        r_load_adr   <= dmem_address;
                        r_load_sel   <= dmem_byte_enable;
                    end else if (r_count != '0) begin
                        r_port_state <= c_P_DRAIN;
                    end
                end
                c_P_DRAIN: if (cache_ack) r_port_state <= c_P_IDLE;
                c_P_LOAD:  if (cache_ack) r_port_state <= c_P_IDLE;
                default:   r_port_state <= c_P_IDLE;
            endcase
        end
    end

    always_comb begin
        cache_cyc   = 1'b0;
        cache_we    = 1'b0;
        cache_sel   = 2'b00;
        cache_adr   = 16'h0000;
        cache_wdata = 16'h0000;
        case (r_port_state)
            c_P_DRAIN: begin
                cache_cyc   = 1'b1;
                cache_we    = 1'b1;
                cache_sel   = r_fifo_mask[r_rd_ptr];
                cache_adr   = {r_fifo_adr[r_rd_ptr], 1'b0};
                cache_wdata = r_fifo_data[r_rd_ptr];
            end
            c_P_LOAD: begin
                cache_cyc = 1'b1;
                cache_sel = r_load_sel;
                cache_adr = r_load_adr;
            end
            default: ;
        endcase
    end

    assign cache_stb     = cache_cyc;
    assign dmem_resp     = (r_req_state == c_R_RESP);
    assign dmem_data_out = r_data_out;
    assign buf_empty     = (r_count == '0);
    assign buf_count     = r_count;

endmodule
`default_nettype wire
